net_stream_adapter: RTL and testbench

- Streaming front/back end for the cached dilated-conv network: the network core consumes one sample per iteration and emits a one-cycle `out_v` pulse with 4 channel outputs.
- The adapter supplies the network's held input sample from an upstream valid/ready stream.
- It captures each 4-channel result frame into a small frame FIFO and serializes frames onto a single W-bit valid/ready output stream, one channel per beat.
- It sits between the sample source (ADC/testbench stream) and the network core, and the downstream consumer.

---
 rtl/net_io_pkg.sv | 18 +
 rtl/frame_fifo.sv | 59 +++++
 rtl/net_stream_adapter.sv | 158 +++++++++++++++
 tb/tb_net_stream_adapter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_io_pkg.sv
// Shared types for the network stream adapter: channel count, frame type and
// serializer state encoding.
package net_io_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;
  localparam int DATA_W   = 16;

  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CH - 1);

  typedef logic signed [DATA_W-1:0] frame_t [0:NUM_CH-1];

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of NUM_CH-channel result frames. Pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module frame_fifo
  import net_io_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic signed [W-1:0] push_data_i [0:NUM_CH-1],
  input  logic                pop_i,
  output logic signed [W-1:0] pop_data_o [0:NUM_CH-1],
  output logic                full_o,
  output logic                empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic signed [W-1:0] mem_q [0:DEPTH-1][0:NUM_CH-1];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
  assign rptr_d  = pop_ok  ? rptr_q + PTR_ONE : rptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem_q[wptr_q[AW-1:0]][c] <= push_data_i[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop_data_o[c] = mem_q[rptr_q[AW-1:0]][c];
    end
  end

endmodule

// File: rtl/net_stream_adapter.sv
// Stream front/back end for the network core: holds the core's input sample and
// serializes 4-channel result frames. Define NET_ADAPTER_UNDERRUN_ZERO_EN to load 0 on underrun.
module net_stream_adapter
  import net_io_pkg::*;
#(
  parameter int W           = 16,
  parameter int FRAME_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic signed [W-1:0] net_inp,
  input  logic signed [W-1:0] net_out [0:NUM_CH-1],
  input  logic                net_out_v,
  output logic signed [W-1:0] m_data,
  output logic [CH_IDX_W-1:0] m_chan,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CNT_W-1:0]    underrun_cnt,
  output logic [CNT_W-1:0]    overflow_cnt,
  output ser_state_e          dbg_state
);

  // Handshakes: a transfer on either stream happens at a rising clk edge where
  // valid and ready are both high; m_* stays stable while m_valid && !m_ready.

  logic                pend_full_q, pend_full_d;
  logic signed [W-1:0] pend_data_q, pend_data_d;
  logic signed [W-1:0] net_inp_q, net_inp_d;
  logic [CNT_W-1:0]    underrun_cnt_q, underrun_cnt_d;
  logic [CNT_W-1:0]    overflow_cnt_q, overflow_cnt_d;

  ser_state_e          state_q, state_d;
  logic [CH_IDX_W-1:0] chan_q, chan_d;
  logic signed [W-1:0] shadow_q [0:NUM_CH-1];
  logic signed [W-1:0] shadow_d [0:NUM_CH-1];

  logic                fifo_pop, fifo_full, fifo_empty;
  logic signed [W-1:0] fifo_rd [0:NUM_CH-1];

  frame_fifo #(
    .W     (W),
    .DEPTH (FRAME_DEPTH)
  ) u_frame_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (net_out_v),
    .push_data_i (net_out),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Input side: a frame-done pulse takes the pending sample first, else a
  // sample offered in the same cycle passes straight through.
  always_comb begin
    pend_full_d    = pend_full_q;
    pend_data_d    = pend_data_q;
    net_inp_d      = net_inp_q;
    underrun_cnt_d = underrun_cnt_q;
    if (net_out_v) begin
      if (pend_full_q) begin
        net_inp_d   = pend_data_q;
        pend_full_d = 1'b0;
      end else if (s_valid) begin
        net_inp_d = s_data;
      end else begin
`ifdef NET_ADAPTER_UNDERRUN_ZERO_EN
        net_inp_d = '0;
`else
        net_inp_d = net_inp_q;
`endif
        if (underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
      end
    end else if (s_valid && !pend_full_q) begin
      pend_full_d = 1'b1;
      pend_data_d = s_data;
    end
  end

  // Fullness is judged before any pop in the same cycle.
  always_comb begin
    overflow_cnt_d = overflow_cnt_q;
    if (net_out_v && fifo_full && (overflow_cnt_q != '1)) begin
      overflow_cnt_d = overflow_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    shadow_d = shadow_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shadow_d = fifo_rd;
          chan_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (chan_q != LAST_CH) begin
            chan_d = chan_q + CH_IDX_W'(1);
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shadow_d = fifo_rd;
            chan_d   = '0;
          end else begin
            chan_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full_q    <= 1'b0;
      pend_data_q    <= '0;
      net_inp_q      <= '0;
      underrun_cnt_q <= '0;
      overflow_cnt_q <= '0;
      state_q        <= IDLE;
      chan_q         <= '0;
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
    end else begin
      pend_full_q    <= pend_full_d;
      pend_data_q    <= pend_data_d;
      net_inp_q      <= net_inp_d;
      underrun_cnt_q <= underrun_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
      state_q        <= state_d;
      chan_q         <= chan_d;
      for (int c = 0; c < NUM_CH; c++) shadow_q[c] <= shadow_d[c];
    end
  end

  assign s_ready      = !pend_full_q;
  assign net_inp      = net_inp_q;
  assign m_valid      = (state_q == SEND);
  assign m_data       = m_valid ? shadow_q[chan_q] : '0;
  assign m_chan       = m_valid ? chan_q : '0;
  assign m_last       = m_valid && (chan_q == LAST_CH);
  assign underrun_cnt = underrun_cnt_q;
  assign overflow_cnt = overflow_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_net_stream_adapter.sv
// Directed bench for net_stream_adapter: reset, pass-through, underrun,
// overflow, backpressure and mid-frame reset, with a beat scoreboard.
module tb_net_stream_adapter;
  import net_io_pkg::*;

  localparam int W = 16;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] s_data;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] net_inp;
  logic signed [W-1:0] net_out [0:NUM_CH-1];
  logic                net_out_v;
  logic signed [W-1:0] m_data;
  logic [CH_IDX_W-1:0] m_chan;
  logic                m_last;
  logic                m_valid;
  logic                m_ready;
  logic [CNT_W-1:0]    underrun_cnt;
  logic [CNT_W-1:0]    overflow_cnt;
  ser_state_e          dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int beats_seen = 0;
  int beat_idx = 0;
  logic [W-1:0] exp_q[$];

  net_stream_adapter #(.W(W), .FRAME_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .net_inp      (net_inp),
    .net_out      (net_out),
    .net_out_v    (net_out_v),
    .m_data       (m_data),
    .m_chan       (m_chan),
    .m_last       (m_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .underrun_cnt (underrun_cnt),
    .overflow_cnt (overflow_cnt),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d, input bit keep);
    net_out[0] = a;
    net_out[1] = b;
    net_out[2] = c;
    net_out[3] = d;
    net_out_v  = 1'b1;
    if (keep) begin
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
    end
    tick();
    net_out_v = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  // Beat monitor: samples at the falling edge, between driver updates.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_chan;
    logic [W-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_chan  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        beat_idx   = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", 32'($unsigned(m_data)), 32'(prev_data));
          check("stall_chan", 32'(m_chan), 32'(prev_chan));
        end
        if (m_valid && m_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'($unsigned(m_data)), 32'(e));
            check("beat_chan", 32'(m_chan), 32'(beat_idx % 4));
            check("beat_last", 32'(m_last), 32'((beat_idx % 4) == 3));
            beat_idx++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = $unsigned(m_data);
        prev_chan  = m_chan;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, n, bubbles;
    logic [W-1:0] exp_inp;

    rst       = 1'b1;
    s_data    = '0;
    s_valid   = 1'b0;
    net_out_v = 1'b0;
    m_ready   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) net_out[c] = '0;

    // 1: reset state, then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_net_inp", 32'($unsigned(net_inp)), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'($unsigned(m_data)), 32'd0);
    check("rst_m_chan", 32'(m_chan), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_overflow", 32'(overflow_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      tick();
      if (m_valid !== 1'b0) n++;
    end
    check("idle_no_valid", 32'(n), 32'd0);
    check("idle_underrun", 32'(underrun_cnt), 32'd0);
    check("idle_overflow", 32'(overflow_cnt), 32'd0);

    // 2: sample pass and first frame latency
    s_data  = 16'sh0100;
    s_valid = 1'b1;
    tick();
    check("pend_full_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    pulse(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    check("t1_net_inp", 32'($unsigned(net_inp)), 32'h0100);
    check("t1_m_valid", 32'(m_valid), 32'd0);
    check("t1_s_ready", 32'(s_ready), 32'd1);
    tick();
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_m_data", 32'($unsigned(m_data)), 32'd1);
    check("t2_m_chan", 32'(m_chan), 32'd0);
    drain(20);

    // 3: underruns
`ifdef NET_ADAPTER_UNDERRUN_ZERO_EN
    exp_inp = '0;
`else
    exp_inp = 16'h0100;
`endif
    for (int k = 0; k < 3; k++) begin
      pulse(16'(7 + k), 16'(8 + k), 16'(9 + k), 16'(10 + k), 1'b1);
      repeat (9) tick();
    end
    check("underrun_cnt_3", 32'(underrun_cnt), 32'd3);
    check("underrun_net_inp", 32'($unsigned(net_inp)), 32'(exp_inp));
    drain(40);

    // 4: overflow with stalled consumer
    m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      pulse(16'(k), 16'(k), 16'(k), 16'(k), k <= 5);
      repeat (39) tick();
    end
    check("overflow_cnt_1", 32'(overflow_cnt), 32'd1);
    check("stalled_valid", 32'(m_valid), 32'd1);
    check("stalled_data", 32'($unsigned(m_data)), 32'd1);
    check("underrun_cnt_9", 32'(underrun_cnt), 32'd9);
    m_ready = 1'b1;
    bs = beats_seen;
    drain(200);
    check("overflow_beats", 32'(beats_seen - bs), 32'd20);

    // 5: toggling backpressure over two back-to-back frames
    m_ready = 1'b0;
    bs = beats_seen;
    pulse(16'd10, 16'd11, 16'd12, 16'd13, 1'b1);
    pulse(16'd20, 16'd21, 16'd22, 16'd23, 1'b1);
    n = 0;
    bubbles = 0;
    while (exp_q.size() != 0 && n < 100) begin
      if (m_valid !== 1'b1) bubbles++;
      m_ready = ~m_ready;
      tick();
      n++;
    end
    check("toggle_in_budget", 32'(n < 100), 32'd1);
    check("toggle_no_bubble", 32'(bubbles), 32'd0);
    check("toggle_beats", 32'(beats_seen - bs), 32'd8);
    check("toggle_idle_after", 32'(m_valid), 32'd0);
    m_ready = 1'b1;

    // 6: reset in the middle of a frame
    pulse(16'h11, 16'h22, 16'h33, 16'h44, 1'b1);
    tick();
    tick();
    tick();
    check("pre_rst_chan", 32'(m_chan), 32'd2);
    rst = 1'b1;
    #1;
    check("async_m_valid", 32'(m_valid), 32'd0);
    check("async_m_data", 32'($unsigned(m_data)), 32'd0);
    check("async_net_inp", 32'($unsigned(net_inp)), 32'd0);
    check("async_underrun", 32'(underrun_cnt), 32'd0);
    check("async_overflow", 32'(overflow_cnt), 32'd0);
    check("async_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    bs = beats_seen;
    repeat (20) tick();
    check("post_rst_no_beats", 32'(beats_seen - bs), 32'd0);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
